// File: rtl/tl_ul_a_arbiter_pkg.sv
// Shared TL-UL constants, arbiter state type and beat-count helper.
package tl_ul_arb_pkg;

   localparam logic [2:0] PUT_FULL    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL = 3'd1;
   localparam logic [2:0] GET         = 3'd4;
   localparam logic [2:0] ACK         = 3'd0;
   localparam logic [2:0] ACK_DATA    = 3'd1;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Number of 32-bit beats a message of 2**size bytes occupies (1..32).
   function automatic logic [5:0] beats_of(input logic [2:0] size);
      if (size <= 3'd2) begin
         return 6'd1;
      end
      return 6'd1 << (size - 3'd2);
   endfunction

endpackage

// File: rtl/tl_ul_a_arbiter_if.sv
// Bundle of both client ports plus the shared manager port.
// slave  : the arbiter's view
// master : the surrounding clients/manager view
interface tl_ul_a_arbiter_if #(
   parameter int SRC_W  = 4,
   parameter int ADDR_W = 32
);
   logic [1:0]             c_a_valid;
   logic [1:0]             c_a_ready;
   logic [1:0][2:0]        c_a_opcode;
   logic [1:0][2:0]        c_a_size;
   logic [1:0][SRC_W-1:0]  c_a_source;
   logic [1:0][ADDR_W-1:0] c_a_address;
   logic [1:0][3:0]        c_a_mask;
   logic [1:0][31:0]       c_a_data;

   logic                   m_a_valid;
   logic                   m_a_ready;
   logic [2:0]             m_a_opcode;
   logic [2:0]             m_a_size;
   logic [SRC_W:0]         m_a_source;
   logic [ADDR_W-1:0]      m_a_address;
   logic [3:0]             m_a_mask;
   logic [31:0]            m_a_data;

   logic                   m_d_valid;
   logic                   m_d_ready;
   logic [2:0]             m_d_opcode;
   logic [2:0]             m_d_size;
   logic [SRC_W:0]         m_d_source;
   logic                   m_d_denied;
   logic [31:0]            m_d_data;

   logic [1:0]             c_d_valid;
   logic [1:0]             c_d_ready;
   logic [2:0]             c_d_opcode;
   logic [2:0]             c_d_size;
   logic [SRC_W-1:0]       c_d_source;
   logic                   c_d_denied;
   logic [31:0]            c_d_data;

   modport slave (
      input  c_a_valid, c_a_opcode, c_a_size, c_a_source, c_a_address, c_a_mask, c_a_data,
      output c_a_ready,
      output m_a_valid, m_a_opcode, m_a_size, m_a_source, m_a_address, m_a_mask, m_a_data,
      input  m_a_ready,
      input  m_d_valid, m_d_opcode, m_d_size, m_d_source, m_d_denied, m_d_data,
      output m_d_ready,
      output c_d_valid, c_d_opcode, c_d_size, c_d_source, c_d_denied, c_d_data,
      input  c_d_ready
   );

   modport master (
      output c_a_valid, c_a_opcode, c_a_size, c_a_source, c_a_address, c_a_mask, c_a_data,
      input  c_a_ready,
      input  m_a_valid, m_a_opcode, m_a_size, m_a_source, m_a_address, m_a_mask, m_a_data,
      output m_a_ready,
      output m_d_valid, m_d_opcode, m_d_size, m_d_source, m_d_denied, m_d_data,
      input  m_d_ready,
      input  c_d_valid, c_d_opcode, c_d_size, c_d_source, c_d_denied, c_d_data,
      output c_d_ready
   );

endinterface

// File: rtl/tl_ul_a_arbiter_outst_ctr.sv
// Per-client in-flight transaction counter with limit flag.
// Simultaneous inc/dec nets to zero; the count never wraps either way.
module tl_ul_outst_ctr #(
   parameter int MAX_OUTST = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [3:0] cnt_o,
   output logic       full_o
);

   localparam logic [3:0] LIMIT = 4'(MAX_OUTST);

   logic [3:0] cnt_q, cnt_d;

   // Next count: saturate at the limit, floor at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i && (cnt_q < LIMIT)) begin
         cnt_d = cnt_q + 4'd1;
      end else if (dec_i && !inc_i && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   // Count register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign full_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/tl_ul_a_arbiter.sv
// Two-client TL-UL arbiter onto one manager port: round-robin A channel with
// Put-burst locking, client tag in the source MSB, D routed back by that tag.
// Optional build macro TL_ARB_PERF_EN adds per-client grant/stall counters.
//
// state | meaning
// IDLE  | arbitrating first beats between eligible clients
// BURST | multi-beat Put in progress, lock_owner muxed until last beat
module tl_ul_a_arbiter
   import tl_ul_arb_pkg::*;
#(
   parameter int SRC_W     = 4,
   parameter int MAX_OUTST = 4,
   parameter int ADDR_W    = 32
) (
   input  logic                clock,
   input  logic                reset_n,
   tl_ul_a_arbiter_if.slave    bus
`ifdef TL_ARB_PERF_EN
   ,
   output logic [1:0][31:0]    perf_grant_cnt,
   output logic [1:0][31:0]    perf_stall_cnt
`endif
);

   arb_state_e state_q, state_d;
   logic       rr_q, rr_d;
   logic       lock_q, lock_d;
   logic [5:0] beat_q, beat_d;
   logic [5:0] d_beat_q, d_beat_d;

   logic       g;
   logic       a_valid;
   logic       a_fire;
   logic       first_fire;
   logic [1:0] elig;
   logic [1:0] full;
   logic [1:0] inc;
   logic [1:0] dec;
   logic [3:0] cnt [2];

   logic       t;
   logic       d_valid;
   logic       d_ready;
   logic       d_fire;
   logic       d_last;
   logic [5:0] d_beats;

   for (genvar i = 0; i < 2; i++) begin : g_ctr
      tl_ul_outst_ctr #(.MAX_OUTST(MAX_OUTST)) u_ctr (
         .clock   (clock),
         .reset_n (reset_n),
         .inc_i   (inc[i]),
         .dec_i   (dec[i]),
         .cnt_o   (cnt[i]),
         .full_o  (full[i])
      );
      assign inc[i] = first_fire && (g == 1'(i));
      assign dec[i] = d_fire && d_last && (t == 1'(i));
   end

   assign elig = bus.c_a_valid & ~full;

   // A-channel grant, burst tracking and next-state.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      lock_d     = lock_q;
      beat_d     = beat_q;
      g          = rr_q;
      a_valid    = 1'b0;
      first_fire = 1'b0;
      case (state_q)
         IDLE: begin
            g       = (elig[0] && elig[1]) ? rr_q : elig[1];
            a_valid = |elig;
         end
         BURST: begin
            g       = lock_q;
            a_valid = bus.c_a_valid[lock_q];
         end
         default: ;
      endcase
      if (!reset_n) begin
         a_valid = 1'b0;
      end
      a_fire = a_valid && bus.m_a_ready;
      if (a_fire) begin
         if (state_q == IDLE) begin
            first_fire = 1'b1;
            rr_d       = ~g;
            if (((bus.c_a_opcode[g] == PUT_FULL) || (bus.c_a_opcode[g] == PUT_PARTIAL)) &&
                (bus.c_a_size[g] > 3'd2)) begin
               beat_d  = beats_of(bus.c_a_size[g]) - 6'd1;
               lock_d  = g;
               state_d = BURST;
            end
         end else begin
            beat_d = beat_q - 6'd1;
            if (beat_q == 6'd1) begin
               state_d = IDLE;
            end
         end
      end
   end

   // D-channel routing and multi-beat response tracking.
   always_comb begin
      t        = bus.m_d_source[SRC_W];
      d_valid  = reset_n && bus.m_d_valid;
      d_ready  = reset_n && bus.c_d_ready[t];
      d_fire   = d_valid && d_ready;
      d_beats  = beats_of(bus.m_d_size);
      d_last   = (bus.m_d_opcode != ACK_DATA) || (d_beats == 6'd1) ||
                 (d_beat_q == (d_beats - 6'd1));
      d_beat_d = d_beat_q;
      if (d_fire) begin
         d_beat_d = d_last ? 6'd0 : (d_beat_q + 6'd1);
      end
   end

   // State registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         rr_q     <= 1'b0;
         lock_q   <= 1'b0;
         beat_q   <= 6'd0;
         d_beat_q <= 6'd0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         lock_q   <= lock_d;
         beat_q   <= beat_d;
         d_beat_q <= d_beat_d;
      end
   end

   assign bus.m_a_valid   = a_valid;
   assign bus.c_a_ready   = a_valid ? (2'(bus.m_a_ready) << g) : 2'b00;
   assign bus.m_a_opcode  = a_valid ? bus.c_a_opcode[g]      : '0;
   assign bus.m_a_size    = a_valid ? bus.c_a_size[g]        : '0;
   assign bus.m_a_source  = a_valid ? {g, bus.c_a_source[g]} : '0;
   assign bus.m_a_address = a_valid ? bus.c_a_address[g]     : '0;
   assign bus.m_a_mask    = a_valid ? bus.c_a_mask[g]        : '0;
   assign bus.m_a_data    = a_valid ? bus.c_a_data[g]        : '0;

   assign bus.m_d_ready   = d_ready;
   assign bus.c_d_valid   = d_valid ? (2'b01 << t) : 2'b00;
   assign bus.c_d_opcode  = d_valid ? bus.m_d_opcode             : '0;
   assign bus.c_d_size    = d_valid ? bus.m_d_size               : '0;
   assign bus.c_d_source  = d_valid ? bus.m_d_source[SRC_W-1:0]  : '0;
   assign bus.c_d_denied  = d_valid ? bus.m_d_denied             : 1'b0;
   assign bus.c_d_data    = d_valid ? bus.m_d_data               : '0;

   // A completed response must belong to a client with something in flight.
   a_no_orphan_d0: assert property (@(posedge clock) disable iff (!reset_n)
      !(dec[0] && (cnt[0] == 4'd0)));
   a_no_orphan_d1: assert property (@(posedge clock) disable iff (!reset_n)
      !(dec[1] && (cnt[1] == 4'd0)));

`ifdef TL_ARB_PERF_EN
   logic [1:0][31:0] grant_q;
   logic [1:0][31:0] stall_q;

   // Saturating first-beat grant and stall counters per client.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         grant_q <= '0;
         stall_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (inc[i] && (grant_q[i] != 32'hFFFF_FFFF)) begin
               grant_q[i] <= grant_q[i] + 32'd1;
            end
            if (bus.c_a_valid[i] && !(a_fire && (g == 1'(i))) &&
                (stall_q[i] != 32'hFFFF_FFFF)) begin
               stall_q[i] <= stall_q[i] + 32'd1;
            end
         end
      end
   end

   assign perf_grant_cnt = grant_q;
   assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_tl_ul_a_arbiter.sv
// Directed bench for tl_ul_a_arbiter: grant order, burst lock, outstanding
// limit, same-cycle inc/dec, mid-burst reset and (optionally) perf counters.
module tb_tl_ul_a_arbiter;
   import tl_ul_arb_pkg::*;

   localparam int SRC_W     = 4;
   localparam int MAX_OUTST = 4;
   localparam int ADDR_W    = 32;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   n_vec   = 0;
   int   n_err   = 0;

   tl_ul_a_arbiter_if #(.SRC_W(SRC_W), .ADDR_W(ADDR_W)) bus ();

`ifdef TL_ARB_PERF_EN
   logic [1:0][31:0] perf_grant_cnt;
   logic [1:0][31:0] perf_stall_cnt;
`endif

   tl_ul_a_arbiter #(.SRC_W(SRC_W), .MAX_OUTST(MAX_OUTST), .ADDR_W(ADDR_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef TL_ARB_PERF_EN
      ,
      .perf_grant_cnt (perf_grant_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic d_resp(input logic [4:0] src);
      bus.m_d_opcode = ACK;
      bus.m_d_size   = 3'd2;
      bus.m_d_source = src;
      bus.m_d_valid  = 1'b1;
      bus.c_d_ready  = 2'b11;
      #1;
      tick();
      bus.m_d_valid  = 1'b0;
   endtask

   task automatic set_get(input int c);
      bus.c_a_opcode[c] = GET;
      bus.c_a_size[c]   = 3'd2;
   endtask

   initial begin
      bus.c_a_valid      = 2'b11;
      bus.c_a_opcode     = '0;
      bus.c_a_size       = '0;
      bus.c_a_source[0]  = 4'h3;
      bus.c_a_source[1]  = 4'h5;
      bus.c_a_address[0] = 32'h1000_0000;
      bus.c_a_address[1] = 32'h2000_0000;
      bus.c_a_mask       = '1;
      bus.c_a_data       = '0;
      bus.m_a_ready      = 1'b1;
      bus.m_d_valid      = 1'b1;
      bus.m_d_opcode     = ACK;
      bus.m_d_size       = 3'd2;
      bus.m_d_source     = 5'h00;
      bus.m_d_denied     = 1'b0;
      bus.m_d_data       = '0;
      bus.c_d_ready      = 2'b11;
      set_get(0);
      set_get(1);

      // Reset: all handshakes held low even with requests pending.
      tick();
      tick();
      chk("rst_m_a_valid", 64'(bus.m_a_valid), 64'd0);
      chk("rst_c_a_ready", 64'(bus.c_a_ready), 64'd0);
      chk("rst_c_d_valid", 64'(bus.c_d_valid), 64'd0);
      chk("rst_m_d_ready", 64'(bus.m_d_ready), 64'd0);
      chk("rst_m_a_addr",  64'(bus.m_a_address), 64'd0);

      // Round-robin alternation of back-to-back Gets.
      reset_n       = 1'b1;
      bus.m_d_valid = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rr_ready",  64'(bus.c_a_ready),  (i % 2 == 0) ? 64'h1 : 64'h2);
         chk("rr_source", 64'(bus.m_a_source), (i % 2 == 0) ? 64'h03 : 64'h15);
         tick();
      end
      bus.c_a_valid = 2'b00;

      // D routing by source MSB, source stripped to client width.
      bus.m_d_valid  = 1'b1;
      bus.m_d_source = 5'h12;
      bus.m_d_opcode = ACK_DATA;
      bus.m_d_data   = 32'hDEAD_BEEF;
      bus.c_d_ready  = 2'b01;
      #1;
      chk("d_valid_route", 64'(bus.c_d_valid), 64'h2);
      chk("d_ready_block", 64'(bus.m_d_ready), 64'd0);
      bus.c_d_ready = 2'b10;
      #1;
      chk("d_ready_pass",  64'(bus.m_d_ready), 64'd1);
      chk("d_source_strip",64'(bus.c_d_source), 64'h2);
      chk("d_data",        64'(bus.c_d_data), 64'hDEAD_BEEF);
      tick();
      bus.m_d_valid = 1'b0;
      d_resp(5'h10);
      d_resp(5'h00);
      d_resp(5'h00);

      // Four-beat PutFull from client 0 locks out client 1.
      bus.c_a_opcode[0] = PUT_FULL;
      bus.c_a_size[0]   = 3'd4;
      bus.c_a_valid     = 2'b11;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("burst_ready",  64'(bus.c_a_ready),  64'h1);
         chk("burst_opcode", 64'(bus.m_a_opcode), 64'(PUT_FULL));
         tick();
      end
      set_get(0);
      #1;
      chk("post_burst_ready", 64'(bus.c_a_ready), 64'h2);
      chk("post_burst_src",   64'(bus.m_a_source[SRC_W]), 64'd1);
      tick();
      bus.c_a_valid = 2'b00;
      d_resp(5'h00);
      d_resp(5'h10);

      // Outstanding limit on client 0; client 1 still served.
      bus.c_a_valid = 2'b01;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("lim_accept", 64'(bus.c_a_ready), 64'h1);
         tick();
      end
      chk("lim_block_ready", 64'(bus.c_a_ready), 64'h0);
      chk("lim_block_valid", 64'(bus.m_a_valid), 64'd0);
      bus.c_a_valid = 2'b11;
      #1;
      chk("lim_other_ready", 64'(bus.c_a_ready), 64'h2);
      tick();
      bus.c_a_valid  = 2'b01;
      bus.m_d_valid  = 1'b1;
      bus.m_d_source = 5'h00;
      bus.m_d_opcode = ACK_DATA;
      bus.m_d_size   = 3'd3;
      bus.c_d_ready  = 2'b11;
      #1;
      tick();
      chk("lim_mid_d_ready", 64'(bus.c_a_ready), 64'h0);
      tick();
      bus.m_d_valid = 1'b0;
      #1;
      chk("lim_unblock", 64'(bus.c_a_ready), 64'h1);

      // Same-cycle A fire and D completion on client 0 at count 3.
      bus.m_d_valid  = 1'b1;
      bus.m_d_opcode = ACK;
      bus.m_d_size   = 3'd2;
      #1;
      chk("same_a_ready", 64'(bus.c_a_ready), 64'h1);
      chk("same_d_ready", 64'(bus.m_d_ready), 64'd1);
      tick();
      bus.m_d_valid = 1'b0;
      #1;
      chk("same_one_left", 64'(bus.c_a_ready), 64'h1);
      tick();
      chk("same_full", 64'(bus.c_a_ready), 64'h0);
      bus.c_a_valid = 2'b00;
      for (int i = 0; i < 4; i++) d_resp(5'h00);
      d_resp(5'h10);

      // Reset after two beats of an eight-beat Put.
      bus.c_a_opcode[0] = PUT_FULL;
      bus.c_a_size[0]   = 3'd5;
      bus.c_a_valid     = 2'b01;
      #1;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(bus.c_a_ready), 64'h0);
      chk("mid_rst_valid", 64'(bus.m_a_valid), 64'd0);
      tick();
      reset_n       = 1'b1;
      bus.m_a_ready = 1'b0;
      bus.c_a_valid = 2'b10;
      #1;
      chk("mid_rst_idle_valid", 64'(bus.m_a_valid),  64'd1);
      chk("mid_rst_idle_src",   64'(bus.m_a_source), 64'h15);
      bus.c_a_valid = 2'b11;
      #1;
      chk("mid_rst_rr0", 64'(bus.m_a_source), 64'h03);
      set_get(0);
      bus.c_a_valid = 2'b01;
      bus.m_a_ready = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("mid_rst_cnt_accept", 64'(bus.c_a_ready), 64'h1);
         tick();
      end
      chk("mid_rst_cnt_full", 64'(bus.c_a_ready), 64'h0);
      bus.c_a_valid = 2'b00;

`ifdef TL_ARB_PERF_EN
      // Client 1 waits three cycles behind a client 0 burst.
      reset_n = 1'b0;
      tick();
      reset_n           = 1'b1;
      bus.c_a_opcode[0] = PUT_FULL;
      bus.c_a_size[0]   = 3'd4;
      bus.c_a_valid     = 2'b01;
      #1;
      tick();
      bus.c_a_valid = 2'b11;
      tick();
      tick();
      tick();
      bus.c_a_valid = 2'b10;
      tick();
      bus.c_a_valid = 2'b00;
      #1;
      chk("perf_stall1", 64'(perf_stall_cnt[1]), 64'd3);
      chk("perf_stall0", 64'(perf_stall_cnt[0]), 64'd0);
      chk("perf_grant0", 64'(perf_grant_cnt[0]), 64'd1);
      chk("perf_grant1", 64'(perf_grant_cnt[1]), 64'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
